// File: rtl/rv32i_mem_pkg.sv
// Purpose: shared types, funct3 codes and access legality for the RV32I load/store path.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package rv32i_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Stores share codes 000/001/010 with LB/LH/LW; 1xx is load-only.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] ea_lo);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~ea_lo[0];
      F3_LW:   ok = (ea_lo == 2'b00);
      F3_LBU:  ok = ~is_store;
      F3_LHU:  ok = ~is_store & ~ea_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Purpose: pick the addressed byte/halfword of a read word and sign/zero-extend it.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module load_extend
  import rv32i_mem_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  ea_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Move the addressed lane down to bit 0, then extend per funct3.
  always_comb begin
    shifted = bus_rdata >> {ea_lo, 3'b000};
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'd0, shifted[7:0]};
      F3_LHU:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Purpose: RV32I load/store unit; one ack-based bus access per instruction, load writeback.
// Latency: accept N, bus strobe N+1, writeback N+2 plus one cycle per ack wait.
// Backpressure: stall holds the core from a legal accept until the DONE cycle; bus waits on bus_ack.
module load_store_unit
  import rv32i_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_read,
  output logic        bus_write,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_en,
  output logic        fault
);

  lsu_state_t  state;
  logic [31:0] ea;
  logic        legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  ea_lo_q;
  logic [4:0]  rd_q;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .bus_rdata (bus_rdata),
    .ea_lo     (ea_lo_q),
    .funct3    (f3_q),
    .load_data (ext_data)
  );

  // Effective address and legality of the request presented this cycle.
  always_comb begin
    ea    = rs1_val + imm;
    legal = access_legal(mem_write, funct3, ea[1:0]);
  end

  // Lane enables and replicated store data for the request presented this cycle.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = 32'd0;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          st_be    = 4'b0001 << ea[1:0];
          st_wdata = {4{rs2_val[7:0]}};
        end
        2'b01: begin
          st_be    = ea[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{rs2_val[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = rs2_val;
        end
      endcase
    end
  end

  // Stall is combinational so the core freezes in the accept cycle; forced low in reset.
  always_comb begin
    stall = rst & (((state == IDLE) & mem_en & legal) | (state == ACCESS));
  end

  // Control FSM with registered bus, writeback and fault outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_be    <= 4'd0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      wb_data   <= 32'd0;
      wb_rd     <= 5'd0;
      wb_en     <= 1'b0;
      fault     <= 1'b0;
      store_q   <= 1'b0;
      f3_q      <= 3'd0;
      ea_lo_q   <= 2'd0;
      rd_q      <= 5'd0;
    end else begin
      fault <= 1'b0;
      wb_en <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_en) begin
            if (!legal) begin
              fault <= 1'b1;
            end else begin
              bus_addr  <= {ea[31:2], 2'b00};
              bus_wdata <= st_wdata;
              bus_be    <= st_be;
              bus_read  <= ~mem_write;
              bus_write <= mem_write;
              store_q   <= mem_write;
              f3_q      <= funct3;
              ea_lo_q   <= ea[1:0];
              rd_q      <= rd;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            wb_data   <= store_q ? 32'd0 : ext_data;
            wb_rd     <= rd_q;
            wb_en     <= ~store_q & (rd_q != 5'd0);
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: self-checking bench for load_store_unit (vector table, random vs model, corner sequences).
// Latency: n/a.
// Backpressure: exercises ack wait states on the memory bus.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_val = 32'd0;
  logic [31:0] rs2_val = 32'd0;
  logic [31:0] imm = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_read;
  logic        bus_write;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_en;
  logic        fault;

  load_store_unit dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .funct3    (funct3),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .rd        (rd),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_read  (bus_read),
    .bus_write (bus_write),
    .stall     (stall),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .wb_en     (wb_en),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          waits;
    logic        e_fault;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_wb_en;
    logic [31:0] e_wb_data;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] im, input logic [4:0] rdn,
                              input logic [31:0] rdata, input int waits, input logic e_fault,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_wb_en,
                              input logic [31:0] e_wb_data);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.imm = im; v.rd = rdn;
    v.rdata = rdata; v.waits = waits; v.e_fault = e_fault; v.e_addr = e_addr;
    v.e_be = e_be; v.e_wdata = e_wdata; v.e_wb_en = e_wb_en; v.e_wb_data = e_wb_data;
    return v;
  endfunction

  // Reference: derive expectations from access size, signedness and byte offset.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    logic [31:0] ea;
    logic [31:0] val;
    int          off;
    int          size;
    bit          sgn;
    bit          ok;
    r    = v;
    ea   = v.rs1 + v.imm;
    off  = int'(ea % 32'd4);
    size = 0;
    sgn  = 1'b0;
    case (v.f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; end
      3'd4: begin size = 1; end
      3'd5: begin size = 2; end
      default: size = 0;
    endcase
    ok = (size != 0) && !(v.wr && v.f3 >= 3'd4);
    if (ok) ok = (off % size) == 0;
    r.e_fault = !ok;
    r.e_addr  = ea - 32'(off);
    r.e_be    = 4'hF;
    r.e_wdata = 32'd0;
    if (v.wr) begin
      if (size == 1) begin
        r.e_be    = 4'(32'd1 << off);
        r.e_wdata = (v.rs2 & 32'hFF) * 32'h01010101;
      end else if (size == 2) begin
        r.e_be    = 4'(32'd3 << off);
        r.e_wdata = (v.rs2 & 32'hFFFF) * 32'h00010001;
      end else begin
        r.e_wdata = v.rs2;
      end
    end
    val = v.rdata >> (8 * off);
    if (size == 1) begin
      val = val & 32'hFF;
      if (sgn && val >= 32'd128) val = val | 32'hFFFFFF00;
    end else if (size == 2) begin
      val = val & 32'hFFFF;
      if (sgn && val >= 32'h8000) val = val | 32'hFFFF0000;
    end
    r.e_wb_en   = ok && !v.wr && (v.rd != 5'd0);
    r.e_wb_data = val;
    return r;
  endfunction

  // Drive one request at a negedge and follow it through to IDLE, checking every phase.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    mem_en = 1'b1; mem_write = v.wr; funct3 = v.f3;
    rs1_val = v.rs1; rs2_val = v.rs2; imm = v.imm; rd = v.rd;
    #1 chk($sformatf("%s.stall_accept", tag), stall, !v.e_fault);
    @(negedge clk);
    mem_en = 1'b0;
    #1;
    if (v.e_fault) begin
      chk($sformatf("%s.fault", tag), fault, 1'b1);
      chk($sformatf("%s.no_read", tag), bus_read, 1'b0);
      chk($sformatf("%s.no_write", tag), bus_write, 1'b0);
      chk($sformatf("%s.stall0", tag), stall, 1'b0);
      @(negedge clk);
      #1 chk($sformatf("%s.fault_drop", tag), fault, 1'b0);
      chk($sformatf("%s.no_wb", tag), wb_en, 1'b0);
      chk($sformatf("%s.no_read2", tag), bus_read, 1'b0);
    end else begin
      chk($sformatf("%s.fault0", tag), fault, 1'b0);
      chk($sformatf("%s.addr", tag), bus_addr, v.e_addr);
      chk($sformatf("%s.be", tag), bus_be, v.e_be);
      chk($sformatf("%s.read", tag), bus_read, !v.wr);
      chk($sformatf("%s.write", tag), bus_write, v.wr);
      if (v.wr) chk($sformatf("%s.wdata", tag), bus_wdata, v.e_wdata);
      chk($sformatf("%s.stall_acc", tag), stall, 1'b1);
      for (int i = 0; i < v.waits; i++) begin
        @(negedge clk);
        #1 chk($sformatf("%s.wait_addr", tag), bus_addr, v.e_addr);
        chk($sformatf("%s.wait_stall", tag), stall, 1'b1);
        chk($sformatf("%s.wait_strobe", tag), bus_read | bus_write, 1'b1);
      end
      bus_ack = 1'b1; bus_rdata = v.rdata;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      #1 chk($sformatf("%s.wb_en", tag), wb_en, v.e_wb_en);
      if (v.e_wb_en) begin
        chk($sformatf("%s.wb_data", tag), wb_data, v.e_wb_data);
        chk($sformatf("%s.wb_rd", tag), wb_rd, v.rd);
      end
      chk($sformatf("%s.stall_done", tag), stall, 1'b0);
      chk($sformatf("%s.strobe_drop", tag), bus_read | bus_write, 1'b0);
      @(negedge clk);
      #1 chk($sformatf("%s.wb_drop", tag), wb_en, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    vec_t rv;

    tbl[0]  = mk(0, 3'b010, 32'h1000, 0, 32'd4, 5, 32'hDEADBEEF, 0, 0, 32'h1004, 4'hF, 0, 1, 32'hDEADBEEF);
    tbl[1]  = mk(0, 3'b000, 32'h2000, 0, 32'd3, 7, 32'h80FFFFFF, 1, 0, 32'h2000, 4'hF, 0, 1, 32'hFFFFFF80);
    tbl[2]  = mk(0, 3'b100, 32'h2000, 0, 32'd3, 7, 32'h80FFFFFF, 0, 0, 32'h2000, 4'hF, 0, 1, 32'h00000080);
    tbl[3]  = mk(1, 3'b001, 32'h3000, 32'h1234ABCD, 32'd2, 4, 0, 0, 0, 32'h3000, 4'hC, 32'hABCDABCD, 0, 0);
    tbl[4]  = mk(0, 3'b010, 32'h1000, 0, 32'd1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 3'b001, 32'h2000, 0, 32'd2, 8, 32'h80011234, 0, 0, 32'h2000, 4'hF, 0, 1, 32'hFFFF8001);
    tbl[6]  = mk(0, 3'b101, 32'h2000, 0, 32'd0, 8, 32'h8001F234, 2, 0, 32'h2000, 4'hF, 0, 1, 32'h0000F234);
    tbl[7]  = mk(1, 3'b000, 32'h4000, 32'h777777A5, 32'd1, 0, 0, 0, 0, 32'h4000, 4'h2, 32'hA5A5A5A5, 0, 0);
    tbl[8]  = mk(1, 3'b010, 32'h5000, 32'hCAFEF00D, 32'd0, 0, 0, 1, 0, 32'h5000, 4'hF, 32'hCAFEF00D, 0, 0);
    tbl[9]  = mk(0, 3'b011, 32'h1000, 0, 32'd0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 3'b100, 32'h1000, 0, 32'd0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 3'b001, 32'h2000, 0, 32'd1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 3'b010, 32'h1008, 0, 32'hFFFFFFFC, 31, 32'h01234567, 0, 0, 32'h1004, 4'hF, 0, 1, 32'h01234567);

    // Reset state.
    #12;
    chk("reset.bus_addr", bus_addr, 32'd0);
    chk("reset.bus_be", bus_be, 4'd0);
    chk("reset.strobes", {bus_read, bus_write}, 2'b00);
    chk("reset.wb_en", wb_en, 1'b0);
    chk("reset.fault", fault, 1'b0);
    chk("reset.stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Long ack wait with a competing request that must be ignored.
    @(negedge clk);
    mem_en = 1'b1; mem_write = 1'b0; funct3 = 3'b010; rs1_val = 32'h6000; imm = 32'd8; rd = 5'd9;
    @(negedge clk);
    mem_write = 1'b1; rs1_val = 32'h7000; imm = 32'd0; rs2_val = 32'h55555555;
    #1 chk("wait.addr0", bus_addr, 32'h6008);
    chk("wait.read0", bus_read, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("wait.addr", bus_addr, 32'h6008);
      chk("wait.read", bus_read, 1'b1);
      chk("wait.write", bus_write, 1'b0);
      chk("wait.stall", stall, 1'b1);
    end
    mem_en = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    @(negedge clk);
    bus_ack = 1'b0;
    #1 chk("wait.wb_en", wb_en, 1'b1);
    chk("wait.wb_data", wb_data, 32'h11223344);
    chk("wait.wb_rd", wb_rd, 5'd9);
    @(negedge clk);
    #1 chk("wait.no_late_write", bus_write, 1'b0);
    chk("wait.no_late_read", bus_read, 1'b0);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    mem_en = 1'b1; mem_write = 1'b0; funct3 = 3'b010; rs1_val = 32'h1000; imm = 32'd0; rd = 5'd3;
    @(negedge clk);
    mem_en = 1'b0;
    #1 chk("arst.pre_read", bus_read, 1'b1);
    #1 rst = 1'b0;
    #1 chk("arst.bus_addr", bus_addr, 32'd0);
    chk("arst.bus_be", bus_be, 4'd0);
    chk("arst.bus_wdata", bus_wdata, 32'd0);
    chk("arst.strobes", {bus_read, bus_write}, 2'b00);
    chk("arst.stall", stall, 1'b0);
    chk("arst.wb", {wb_en, fault, wb_rd}, 7'd0);
    chk("arst.wb_data", wb_data, 32'd0);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    rst = 1'b1;
    rv = model(mk(0, 3'b010, 32'h1000, 0, 32'd0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0));
    run_vec(rv, "rd0");

    // Randomized requests against the reference model.
    for (int n = 0; n < 150; n++) begin
      rv.wr    = 1'($urandom_range(0, 1));
      rv.f3    = 3'($urandom_range(0, 7));
      rv.rs1   = $urandom;
      rv.rs2   = $urandom;
      rv.imm   = 32'($urandom_range(0, 63)) - 32'd32;
      rv.rd    = 5'($urandom_range(0, 31));
      rv.rdata = $urandom;
      rv.waits = $urandom_range(0, 3);
      rv = model(rv);
      run_vec(rv, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
